// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and address helpers for the instruction-memory responder.
package imem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [ADDR_W-3:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

  // Index compared at full width so large byte addresses never alias into the array.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] depth);
    return {2'b00, addr[ADDR_W-1:2]} < depth;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port, one registered read port, contents not reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: accepts PC requests, returns the instruction one cycle later on a
// valid/ready channel; flush discards the pending response, load writes the array.
module imem_responder
  import imem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD    = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_instruction,
  output logic [ADDR_W-1:0] resp_pc,
  output logic              resp_fault,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

  state_t            state;
  logic              use_ram;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-3:0] fetch_idx, load_idx;
  logic              accept, fetch_fault, load_ok;

  assign fetch_idx   = word_index(fetch_addr);
  assign load_idx    = word_index(load_addr);
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) || !in_range(fetch_addr, DEPTH_L);
  assign load_ok     = load_en && in_range(load_addr, DEPTH_L);

  assign resp_valid  = (state == FULL);
  assign fetch_ready = !reset && !flush && !load_en && (!resp_valid || resp_ready);
  assign accept      = fetch_valid && fetch_ready;

  imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (load_ok),
    .waddr (load_idx[AW-1:0]),
    .wdata (load_data),
    .re    (accept && !fetch_fault),
    .raddr (fetch_idx[AW-1:0]),
    .rdata (rdata)
  );

  // The RAM data register only updates on a good accept, so it holds with the response.
  assign resp_instruction = use_ram ? rdata : NOP_WORD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      resp_pc    <= '0;
      resp_fault <= 1'b0;
      use_ram    <= 1'b0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (accept) begin
      state      <= FULL;
      resp_pc    <= fetch_addr;
      resp_fault <= fetch_fault;
      use_ram    <= !fetch_fault;
    end else if (resp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed, table-driven check of the fetch responder: streaming, stall, faults,
// flush, load collision and reset behaviour.
module tb_imem_responder;
  localparam int DEPTH = 16;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, fetch_valid, fetch_ready, resp_valid, resp_ready;
  logic [31:0] fetch_addr, resp_instruction, resp_pc, load_addr, load_data;
  logic        resp_fault, flush, load_en;

  int passed = 0;
  int total  = 0;

  imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_addr(fetch_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instruction(resp_instruction), .resp_pc(resp_pc), .resp_fault(resp_fault),
    .flush(flush), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] addr;
    logic        rr;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic        ex_fault;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string name, input logic [31:0] instr,
                          input logic [31:0] pc, input logic fault);
    chk({name, ".valid"}, 32'(resp_valid), 32'd1);
    chk({name, ".instr"}, resp_instruction, instr);
    chk({name, ".pc"}, resp_pc, pc);
    chk({name, ".fault"}, 32'(resp_fault), 32'(fault));
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    #1 chk("load_blocks_ready", 32'(fetch_ready), 32'd0);
    tick();
    load_en = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; resp_ready = 1'b0;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    #1 chk("ready_in_reset", 32'(fetch_ready), 32'd0);
    tick();
    chk("reset_valid", 32'(resp_valid), 32'd0);
    chk("reset_instr", resp_instruction, NOP);
    chk("reset_pc", resp_pc, 32'd0);
    chk("reset_fault", 32'(resp_fault), 32'd0);
    reset = 1'b0;

    load(32'h0, 32'h1111_1111);
    load(32'h4, 32'h2222_2222);
    load(32'h8, 32'h3333_3333);

    vecs[0] = '{1'b1, 32'h0,         1'b1, 1'b1, 32'h1111_1111, 1'b0};
    vecs[1] = '{1'b1, 32'h4,         1'b1, 1'b1, 32'h2222_2222, 1'b0};
    vecs[2] = '{1'b1, 32'h8,         1'b1, 1'b1, 32'h3333_3333, 1'b0};
    vecs[3] = '{1'b1, 32'h6,         1'b1, 1'b1, NOP,           1'b1};
    vecs[4] = '{1'b1, 32'(4*DEPTH),  1'b1, 1'b1, NOP,           1'b1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, NOP,           1'b1};
    vecs[6] = '{1'b0, 32'h0,         1'b1, 1'b0, NOP,           1'b0};

    for (int i = 0; i < 7; i++) begin
      fetch_valid = vecs[i].fv; fetch_addr = vecs[i].addr; resp_ready = vecs[i].rr;
      #1 chk($sformatf("vec%0d.ready", i), 32'(fetch_ready), 32'd1);
      tick();
      if (vecs[i].ex_valid)
        chk_resp($sformatf("vec%0d", i), vecs[i].ex_instr, vecs[i].addr, vecs[i].ex_fault);
      else
        chk($sformatf("vec%0d.valid", i), 32'(resp_valid), 32'd0);
    end

    // Stall: response held while ID is not ready.
    fetch_valid = 1'b1; fetch_addr = 32'h4; resp_ready = 1'b0;
    tick();
    fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      chk("stall.ready", 32'(fetch_ready), 32'd0);
      tick();
      chk_resp("stall", 32'h2222_2222, 32'h4, 1'b0);
    end
    resp_ready = 1'b1;
    #1 chk("release.ready", 32'(fetch_ready), 32'd1);
    tick();
    chk_resp("release", 32'h3333_3333, 32'h8, 1'b0);
    fetch_valid = 1'b0;
    tick();
    chk("drain.valid", 32'(resp_valid), 32'd0);

    // Flush discards the pending response and blocks acceptance that cycle.
    fetch_valid = 1'b1; fetch_addr = 32'h8;
    tick();
    chk_resp("pre_flush", 32'h3333_3333, 32'h8, 1'b0);
    flush = 1'b1; fetch_addr = 32'h0;
    #1 chk("flush.ready", 32'(fetch_ready), 32'd0);
    tick();
    chk("flush.valid", 32'(resp_valid), 32'd0);
    flush = 1'b0;
    tick();
    chk_resp("post_flush", 32'h1111_1111, 32'h0, 1'b0);
    fetch_valid = 1'b0;
    tick();

    // Load wins over a simultaneous fetch; the fetch the next cycle sees new data.
    load_en = 1'b1; load_addr = 32'h4; load_data = 32'hDEAD_BEEF;
    fetch_valid = 1'b1; fetch_addr = 32'h4;
    #1 chk("collide.ready", 32'(fetch_ready), 32'd0);
    tick();
    chk("collide.valid", 32'(resp_valid), 32'd0);
    load_en = 1'b0;
    tick();
    chk_resp("after_load", 32'hDEAD_BEEF, 32'h4, 1'b0);
    fetch_valid = 1'b0;
    tick();

    // Out-of-range load must not alias onto word 0.
    load(32'(4*DEPTH), 32'hBAD0_BAD0);

    // Reset while holding a response; memory survives.
    fetch_valid = 1'b1; fetch_addr = 32'h8; resp_ready = 1'b0;
    tick();
    chk_resp("pre_reset", 32'h3333_3333, 32'h8, 1'b0);
    reset = 1'b1; fetch_valid = 1'b0;
    #1 chk("reset.ready", 32'(fetch_ready), 32'd0);
    tick();
    chk("mid_reset.valid", 32'(resp_valid), 32'd0);
    chk("mid_reset.instr", resp_instruction, NOP);
    chk("mid_reset.pc", resp_pc, 32'd0);
    chk("mid_reset.fault", 32'(resp_fault), 32'd0);
    reset = 1'b0; fetch_valid = 1'b1; fetch_addr = 32'h0; resp_ready = 1'b1;
    tick();
    chk_resp("mem_kept", 32'h1111_1111, 32'h0, 1'b0);
    fetch_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
